// File: rtl/iap2_pkg.sv
// iap2_pkg: shared iAP2 link constants, control-byte masks and parser FSM states
package iap2_pkg;

    localparam logic [7:0]  IAP2_SOP_MSB     = 8'hFF;
    localparam logic [7:0]  IAP2_SOP_LSB     = 8'h5A;
    localparam logic [7:0]  IAP2_DET_LSB     = 8'h55;
    localparam logic [7:0]  IAP2_CTRL_TOKEN  = 8'h40;
    localparam logic [15:0] IAP2_HDR_LEN     = 16'd9;
    localparam logic [23:0] IAP2_DET_SEQ     = 24'h0200EE;
    localparam logic [7:0]  IAP2_DET_IAP2    = 8'h10;
    localparam logic [7:0]  IAP2_DET_ANDROID = 8'h20;

    localparam logic [7:0] IAP2_CTRL_SYN = 8'h80;
    localparam logic [7:0] IAP2_CTRL_ACK = 8'h40;
    localparam logic [7:0] IAP2_CTRL_EAK = 8'h20;
    localparam logic [7:0] IAP2_CTRL_RST = 8'h10;
    localparam logic [7:0] IAP2_CTRL_SLP = 8'h08;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SOP,
        S_DET,
        S_HDR,
        S_PAYLOAD,
        S_MSG_HDR,
        S_PAR_HDR,
        S_PAR_DATA,
        S_DROP
    } iap2_state_e;

endpackage

// File: rtl/iap2_rx_sync.sv
// iap2_rx_sync: input synchroniser, endpoint-qualified byte strobe and end-of-transfer detect
module iap2_rx_sync #(
    parameter int ENDPT_NUM   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_endpt_sel,
    input  logic       i_usb_rxact,
    input  logic       i_usb_rxval,
    input  logic [7:0] i_usb_rxdat,
    output logic       o_act,
    output logic       o_acc,
    output logic       o_eot,
    output logic [7:0] o_dat
);

    logic [13:0] pipe_q [SYNC_STAGES];
    logic        act_q, val_q, hit_q, prev_q;
    logic [7:0]  dat_q;

    // shift raw inputs through the synchroniser chain
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pipe_q <= '{default: '0};
        end else begin
            pipe_q[0] <= {i_endpt_sel, i_usb_rxact, i_usb_rxval, i_usb_rxdat};
            for (int k = 1; k < SYNC_STAGES; k++)
                pipe_q[k] <= pipe_q[k-1];
        end
    end

    // register the endpoint compare alongside the data it qualifies
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            {act_q, val_q, dat_q, hit_q, prev_q} <= '0;
        end else begin
            {act_q, val_q, dat_q} <= pipe_q[SYNC_STAGES-1][9:0];
            hit_q  <= pipe_q[SYNC_STAGES-1][13:10] == 4'(ENDPT_NUM);
            prev_q <= act_q & hit_q;
        end
    end

    assign o_act = act_q;
    assign o_acc = act_q & val_q & hit_q;
    assign o_eot = prev_q & ~act_q;
    assign o_dat = dat_q;

endmodule

// File: rtl/iap2_link_parser.sv
// iap2_link_parser: iAP2 link packet, control message and detect-sequence decoder
module iap2_link_parser
    import iap2_pkg::*;
#(
    parameter int ENDPT_NUM   = 2,
    parameter int SYNC_STAGES = 2,
    parameter bit CHECK_CSUM  = 1'b1
) (
    input  logic        i_usb_user_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_endpt_sel,
    input  logic        i_usb_rxact,
    input  logic        i_usb_rxval,
    input  logic [7:0]  i_usb_rxdat,
    output logic        o_detect,
    output logic        o_android,
    output logic        o_pkt_done,
    output logic        o_pkt_ok,
    output logic [7:0]  o_pkt_ctrl,
    output logic [7:0]  o_pkt_seq,
    output logic [7:0]  o_pkt_ack,
    output logic [7:0]  o_pkt_sid,
    output logic [15:0] o_pkt_len,
    output logic        o_err_hdr_csum,
    output logic        o_err_pl_csum,
    output logic        o_err_len,
    output logic        o_msg_vld,
    output logic [15:0] o_msg_id,
    output logic        o_param_vld,
    output logic        o_param_first,
    output logic        o_param_last,
    output logic [15:0] o_param_id,
    output logic [15:0] o_param_len,
    output logic [7:0]  o_param_data
);

    logic        act, acc, eot;
    logic [7:0]  dat;
    iap2_state_e state_q;
    logic [15:0] cnt_q, len_q, msg_end_q, plen_q, pcnt_q;
    logic [7:0]  prv_q, hsum_q, psum_q;
    logic [1:0]  det_q, ph_q;
    logic        is_pkt_q, err_len_q;
    logic [15:0] word;
    logic [16:0] par_end;
    logic [7:0]  det_exp;
    logic        is_cks, msg_more, len_bad, hdr_bad, pl_bad;

    iap2_rx_sync #(.ENDPT_NUM(ENDPT_NUM), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk(i_usb_user_clk), .i_rst(i_rst), .i_endpt_sel(i_endpt_sel),
        .i_usb_rxact(i_usb_rxact), .i_usb_rxval(i_usb_rxval), .i_usb_rxdat(i_usb_rxdat),
        .o_act(act), .o_acc(acc), .o_eot(eot), .o_dat(dat)
    );

    assign word     = {prv_q, dat};
    assign par_end  = {1'b0, cnt_q} + {1'b0, plen_q} - 17'd3;
    assign det_exp  = cnt_q == 16'd2 ? IAP2_DET_SEQ[23:16] : cnt_q == 16'd3 ? IAP2_DET_SEQ[15:8] : IAP2_DET_SEQ[7:0];
    assign is_cks   = state_q inside {S_PAYLOAD, S_MSG_HDR, S_PAR_HDR, S_PAR_DATA} && cnt_q == len_q - 16'd1;
    assign msg_more = cnt_q + 16'd1 < msg_end_q;
    assign len_bad  = err_len_q || cnt_q != len_q;
    assign hdr_bad  = hsum_q != 8'd0;
    assign pl_bad   = len_q > IAP2_HDR_LEN && psum_q != 8'd0;

    // byte counter plus header (bytes 0..8) and payload (9..len-1) running sums, cleared between transfers
    always_ff @(posedge i_usb_user_clk) begin
        if (i_rst || !act) begin
            {cnt_q, hsum_q, psum_q} <= '0;
        end else if (acc) begin
            cnt_q <= cnt_q == 16'hFFFF ? cnt_q : cnt_q + 16'd1;
            if (cnt_q < IAP2_HDR_LEN)
                hsum_q <= hsum_q + dat;
            else if (cnt_q < len_q)
                psum_q <= psum_q + dat;
        end
    end

    // packet/message FSM with registered outputs; end of transfer reports then returns to IDLE
    always_ff @(posedge i_usb_user_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            {len_q, msg_end_q, plen_q, pcnt_q, prv_q, det_q, ph_q, is_pkt_q, err_len_q} <= '0;
            {o_detect, o_android, o_pkt_done, o_pkt_ok, o_pkt_ctrl, o_pkt_seq, o_pkt_ack, o_pkt_sid} <= '0;
            {o_err_hdr_csum, o_err_pl_csum, o_err_len, o_msg_vld, o_msg_id} <= '0;
            {o_param_vld, o_param_first, o_param_last, o_param_id, o_param_len, o_param_data} <= '0;
        end else begin
            {o_detect, o_android, o_pkt_done, o_msg_vld, o_param_vld, o_param_first, o_param_last} <= '0;
            if (eot) begin
                o_detect  <= state_q == S_DET && cnt_q == 16'd6 && det_q == 2'b01;
                o_android <= state_q == S_DET && cnt_q == 16'd6 && det_q == 2'b10;
                if (is_pkt_q) begin
                    o_pkt_done     <= 1'b1;
                    o_pkt_ok       <= !len_bad && !(CHECK_CSUM && (hdr_bad || pl_bad));
                    o_err_hdr_csum <= hdr_bad;
                    o_err_pl_csum  <= pl_bad;
                    o_err_len      <= len_bad;
                end
            end
            if (!act) begin
                state_q <= S_IDLE;
                {det_q, ph_q, is_pkt_q, err_len_q} <= '0;
            end else if (acc) begin
                prv_q <= dat;
                if (is_cks) begin
                    state_q <= S_DROP;
                end else begin
                    case (state_q)
                        S_IDLE: state_q <= dat == IAP2_SOP_MSB ? S_SOP : S_DROP;
                        S_SOP: begin
                            is_pkt_q <= dat == IAP2_SOP_LSB;
                            state_q  <= dat == IAP2_SOP_LSB ? S_HDR : dat == IAP2_DET_LSB ? S_DET : S_DROP;
                        end
                        S_DET: begin
                            if (cnt_q == 16'd5 && (dat == IAP2_DET_IAP2 || dat == IAP2_DET_ANDROID))
                                det_q <= {dat == IAP2_DET_ANDROID, dat == IAP2_DET_IAP2};
                            else if (cnt_q >= 16'd5 || dat != det_exp)
                                state_q <= S_DROP;
                        end
                        S_HDR: begin
                            if (cnt_q == 16'd2) len_q[15:8] <= dat;
                            if (cnt_q == 16'd3) len_q[7:0]  <= dat;
                            if (cnt_q == 16'd4) o_pkt_ctrl  <= dat;
                            if (cnt_q == 16'd5) o_pkt_seq   <= dat;
                            if (cnt_q == 16'd6) o_pkt_ack   <= dat;
                            if (cnt_q == 16'd7) o_pkt_sid   <= dat;
                            if (cnt_q == 16'd8) begin
                                state_q   <= len_q > IAP2_HDR_LEN ? S_PAYLOAD : S_DROP;
                                err_len_q <= err_len_q || len_q < IAP2_HDR_LEN;
                            end
                        end
                        S_PAYLOAD: begin
                            if (cnt_q == 16'd10 && prv_q == IAP2_CTRL_TOKEN && dat == IAP2_CTRL_TOKEN)
                                state_q <= S_MSG_HDR;
                        end
                        S_MSG_HDR: begin
                            if (cnt_q == 16'd12)
                                msg_end_q <= IAP2_HDR_LEN + word;
                            if (cnt_q == 16'd14) begin
                                o_msg_id  <= word;
                                o_msg_vld <= 1'b1;
                                state_q   <= msg_end_q > 16'd15 ? S_PAR_HDR : S_PAYLOAD;
                            end
                        end
                        S_PAR_HDR: begin
                            ph_q <= ph_q + 2'd1;
                            if (ph_q == 2'd1)
                                plen_q <= word;
                            if (ph_q == 2'd3) begin
                                o_param_id  <= word;
                                o_param_len <= plen_q - 16'd4;
                                pcnt_q      <= '0;
                                if (plen_q < 16'd4 || par_end > {1'b0, msg_end_q}) begin
                                    err_len_q <= 1'b1;
                                    state_q   <= S_DROP;
                                end else if (plen_q == 16'd4) begin
                                    state_q <= msg_more ? S_PAR_HDR : S_PAYLOAD;
                                end else begin
                                    state_q <= S_PAR_DATA;
                                end
                            end
                        end
                        S_PAR_DATA: begin
                            o_param_vld   <= 1'b1;
                            o_param_data  <= dat;
                            o_param_first <= pcnt_q == 16'd0;
                            o_param_last  <= pcnt_q + 16'd1 == o_param_len;
                            pcnt_q        <= pcnt_q + 16'd1;
                            if (pcnt_q + 16'd1 == o_param_len)
                                state_q <= msg_more ? S_PAR_HDR : S_PAYLOAD;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign o_pkt_len = len_q;

endmodule

// File: tb/tb_iap2_link_parser.sv
// tb_iap2_link_parser: scoreboard bench for the iAP2 link parser (CHECK_CSUM=1 and CHECK_CSUM=0 instances)
module tb_iap2_link_parser;

    typedef struct packed {
        logic [7:0]  ctrl, seq, ack, sid;
        logic [15:0] len;
        logic        eh, epl, el, ok1, ok0, cpl;
    } pkt_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic [3:0] ep  = '0;
    logic       act = 1'b0, val = 1'b0;
    logic [7:0] dat = '0;

    logic        det, andr, done, ok, ehdr, epl, elen, mvld, pvld, pfirst, plast;
    logic [7:0]  ctrl, seq, ack, sid, pdat;
    logic [15:0] len, mid, pid, plen;
    logic        det1, andr1, done1, ok1, ehdr1, epl1, elen1, mvld1, pvld1, pfirst1, plast1;
    logic [7:0]  ctrl1, seq1, ack1, sid1, pdat1;
    logic [15:0] len1, mid1, pid1, plen1;

    logic [1:0]  dq[$];
    logic [15:0] mq[$];
    logic [41:0] parq[$];
    pkt_t        pq0[$], pq1[$];
    logic [7:0]  tx[$], pl[$];

    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    iap2_link_parser u0 (
        .i_usb_user_clk(clk), .i_rst(rst), .i_endpt_sel(ep), .i_usb_rxact(act), .i_usb_rxval(val), .i_usb_rxdat(dat),
        .o_detect(det), .o_android(andr), .o_pkt_done(done), .o_pkt_ok(ok), .o_pkt_ctrl(ctrl), .o_pkt_seq(seq),
        .o_pkt_ack(ack), .o_pkt_sid(sid), .o_pkt_len(len), .o_err_hdr_csum(ehdr), .o_err_pl_csum(epl),
        .o_err_len(elen), .o_msg_vld(mvld), .o_msg_id(mid), .o_param_vld(pvld), .o_param_first(pfirst),
        .o_param_last(plast), .o_param_id(pid), .o_param_len(plen), .o_param_data(pdat)
    );

    iap2_link_parser #(.CHECK_CSUM(1'b0)) u1 (
        .i_usb_user_clk(clk), .i_rst(rst), .i_endpt_sel(ep), .i_usb_rxact(act), .i_usb_rxval(val), .i_usb_rxdat(dat),
        .o_detect(det1), .o_android(andr1), .o_pkt_done(done1), .o_pkt_ok(ok1), .o_pkt_ctrl(ctrl1), .o_pkt_seq(seq1),
        .o_pkt_ack(ack1), .o_pkt_sid(sid1), .o_pkt_len(len1), .o_err_hdr_csum(ehdr1), .o_err_pl_csum(epl1),
        .o_err_len(elen1), .o_msg_vld(mvld1), .o_msg_id(mid1), .o_param_vld(pvld1), .o_param_first(pfirst1),
        .o_param_last(plast1), .o_param_id(pid1), .o_param_len(plen1), .o_param_data(pdat1)
    );

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] e, input int n);
        ep  = e;
        act = 1'b1;
        @(posedge clk) #1;
        for (int i = 0; i < n; i++) begin
            val = 1'b1;
            dat = tx[i];
            @(posedge clk) #1;
        end
        val = 1'b0;
        @(posedge clk) #1;
        act = 1'b0;
        repeat (8) @(posedge clk) #1;
    endtask

    task automatic build_link(input logic [7:0] c, s, a, i, input bit corrupt);
        logic [15:0] l;
        logic [7:0]  sum;
        l = pl.size() == 0 ? 16'd9 : 16'(10 + pl.size());
        tx = '{8'hFF, 8'h5A, l[15:8], l[7:0], c, s, a, i};
        sum = '0;
        foreach (tx[k]) sum += tx[k];
        tx.push_back(8'h00 - sum);
        if (pl.size() != 0) begin
            sum = '0;
            foreach (pl[k]) begin
                tx.push_back(pl[k]);
                sum += pl[k];
            end
            tx.push_back(8'h00 - sum + (corrupt ? 8'd1 : 8'd0));
        end
    endtask

    task automatic push_pkt(input logic [7:0] c, s, a, i, input logic [15:0] l, input bit el, ep_err, cpl);
        pkt_t e;
        e = '{ctrl: c, seq: s, ack: a, sid: i, len: l, eh: 1'b0, epl: ep_err, el: el,
              ok1: !el && !ep_err, ok0: !el, cpl: cpl};
        pq0.push_back(e);
        pq1.push_back(e);
    endtask

    // message AA02: param 0000 with 20 data bytes, then empty param 0001
    task automatic build_ctrl_pl();
        pl = '{8'h40, 8'h40, 8'h00, 8'h22, 8'hAA, 8'h02, 8'h00, 8'h18, 8'h00, 8'h00};
        for (int i = 0; i < 20; i++) pl.push_back(8'(i * 13 + 5));
        pl.push_back(8'h00); pl.push_back(8'h04); pl.push_back(8'h00); pl.push_back(8'h01);
    endtask

    task automatic ctrl_pkt(input bit corrupt);
        build_ctrl_pl();
        build_link(8'h40, 8'h05, 8'h2B, 8'h01, corrupt);
        mq.push_back(16'hAA02);
        for (int i = 0; i < 20; i++)
            parq.push_back({16'h0000, 16'h0014, 8'(i * 13 + 5), i == 0, i == 19});
        push_pkt(8'h40, 8'h05, 8'h2B, 8'h01, 16'h002C, 1'b0, corrupt, 1'b1);
        send(4'd2, tx.size());
    endtask

    // scoreboard for the CHECK_CSUM=1 instance
    always @(negedge clk) begin : mon0
        pkt_t e;
        if (det === 1'b1 || andr === 1'b1) begin
            if (dq.size() == 0) check("det_unexp", {andr, det}, 0);
            else check("det", {andr, det}, dq.pop_front());
        end
        if (done === 1'b1) begin
            if (pq0.size() == 0) check("pkt_unexp", 1, 0);
            else begin
                e = pq0.pop_front();
                check("ctrl", ctrl, e.ctrl);
                check("seq", seq, e.seq);
                check("ack", ack, e.ack);
                check("sid", sid, e.sid);
                check("len", len, e.len);
                check("err_hdr", ehdr, e.eh);
                check("err_len", elen, e.el);
                if (e.cpl) check("err_pl", epl, e.epl);
                check("ok", ok, e.ok1);
            end
        end
        if (mvld === 1'b1) begin
            if (mq.size() == 0) check("msg_unexp", mid, 0);
            else check("msg_id", mid, mq.pop_front());
        end
        if (pvld === 1'b1) begin
            if (parq.size() == 0) check("param_unexp", {pid, plen, pdat, pfirst, plast}, 0);
            else check("param", {pid, plen, pdat, pfirst, plast}, parq.pop_front());
        end
    end

    // scoreboard for the CHECK_CSUM=0 instance
    always @(negedge clk) begin : mon1
        pkt_t e;
        if (done1 === 1'b1) begin
            if (pq1.size() == 0) check("pkt_unexp_nocs", 1, 0);
            else begin
                e = pq1.pop_front();
                check("err_len_nocs", elen1, e.el);
                if (e.cpl) check("err_pl_nocs", epl1, e.epl);
                check("ok_nocs", ok1, e.ok0);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst0_len", len, 0);
        check("rst0_any", |{det, andr, done, ok, ctrl, seq, ack, sid, ehdr, epl, elen, mvld, mid, pvld, pfirst, plast, pid, plen, pdat}, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk) #1;

        tx = '{8'hFF, 8'h55, 8'h02, 8'h00, 8'hEE, 8'h10};
        dq.push_back(2'b01);
        send(4'd2, 6);
        send(4'd3, 6);
        tx = '{8'hFF, 8'h55, 8'h02, 8'h00, 8'hEE, 8'h20};
        dq.push_back(2'b10);
        send(4'd2, 6);
        tx = '{8'hFF, 8'h00, 8'h02, 8'h00, 8'hEE, 8'h10};
        send(4'd2, 6);

        pl.delete();
        build_link(8'hC0, 8'h2B, 8'h11, 8'h00, 1'b0);
        push_pkt(8'hC0, 8'h2B, 8'h11, 8'h00, 16'h0009, 1'b0, 1'b0, 1'b1);
        send(4'd2, tx.size());

        ctrl_pkt(1'b0);
        ctrl_pkt(1'b1);

        pl.delete();
        for (int i = 0; i < 22; i++) pl.push_back(8'(i + 1));
        build_link(8'h40, 8'h07, 8'h2C, 8'h02, 1'b0);
        push_pkt(8'h40, 8'h07, 8'h2C, 8'h02, 16'h0020, 1'b1, 1'b0, 1'b0);
        send(4'd2, 24);

        build_ctrl_pl();
        build_link(8'h40, 8'h09, 8'h2D, 8'h01, 1'b0);
        ep  = 4'd2;
        act = 1'b1;
        @(posedge clk) #1;
        for (int i = 0; i < 12; i++) begin
            val = 1'b1;
            dat = tx[i];
            @(posedge clk) #1;
        end
        check("hdr_len_live", len, 16'h002C);
        rst = 1'b1;
        dat = tx[12];
        @(posedge clk) #1;
        rst = 1'b0;
        check("rst_len", len, 0);
        check("rst_any", |{det, andr, done, ok, ctrl, seq, ack, sid, ehdr, epl, elen, mvld, mid, pvld, pfirst, plast, pid, plen, pdat}, 0);
        for (int i = 13; i < tx.size(); i++) begin
            dat = tx[i];
            @(posedge clk) #1;
        end
        val = 1'b0;
        @(posedge clk) #1;
        act = 1'b0;
        repeat (8) @(posedge clk) #1;

        ctrl_pkt(1'b0);

        repeat (20) @(posedge clk) #1;
        check("det_left", dq.size(), 0);
        check("pkt_left", pq0.size(), 0);
        check("pkt_left_nocs", pq1.size(), 0);
        check("msg_left", mq.size(), 0);
        check("param_left", parq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
